lotr_uart_snapshot: RTL and testbench
=====================================

# lotr_uart_snapshot

On-chip counterpart of the simulation memory snapshot: on a start pulse it reads a range of LOTR data memory word by word through a synchronous read port. It transmits each word over a UART TX line as the ASCII line `Offset XXXXXXXX : YYYYYYYY\n`, the same format as the end-of-test shared-memory log. It sits next to the `lotr` FPGA top, driven by a button and wired to a tile's data-memory read port and a board TX pin. Silicon runs can then produce snapshots that diff directly against simulation logs.

## Interface
- `BAUD_DIV`, 434: QClk cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- `DUMP_START`, 32'h0040_0C00: first byte address dumped; multiple of 4.
- `DUMP_END`, 32'h0040_1000: exclusive end byte address; multiple of 4, > `DUMP_START`.

- `QClk` in 1: clock.
- `RstQnnnH` in 1: reset, synchronous, active-high.
- `StartQnnnH` in 1: start request, sampled each cycle.
- `MemRdEnQ100H` out 1: read strobe to data memory.
- `MemAdrsQ100H` out 32: byte address of word read; valid when `MemRdEnQ100H`=1.
- `MemRdDataQ101H` in 32: read data, valid exactly 1 cycle after `MemRdEnQ100H`; byte at addr+3 in [31:24].
- `UartTxQnnnH` out 1: serial out, 8N1, LSB first, idle high.
- `BusyQnnnH` out 1: high from the cycle after start is accepted until `DoneQnnnH`.
- `DoneQnnnH` out 1: one-cycle pulse after the final stop bit.

## Operation
- Reset values:
  - `UartTxQnnnH`=1.
  - `MemRdEnQ100H`=0.
  - `MemAdrsQ100H`=0.
  - `BusyQnnnH`=0.
  - `DoneQnnnH`=0.
  - FSM = IDLE.
  - Address counter = `DUMP_START`.
- FSM states: IDLE, RD_REQ, RD_CAP, TX_CHAR, NEXT_WORD, DONE.
  - IDLE → RD_REQ on `StartQnnnH`=1.
  - RD_REQ: assert `MemRdEnQ100H` with `MemAdrsQ100H`=addr → RD_CAP.
  - RD_CAP: latch `MemRdDataQ101H` into the data register; char index=0 → TX_CHAR.
  - TX_CHAR: serialize char[index]; when its stop bit ends, index+1. After index 26 → NEXT_WORD.
  - NEXT_WORD: if addr+4 == `DUMP_END` → DONE, else addr += 4 → RD_REQ.
  - DONE: pulse `DoneQnnnH`, drop `BusyQnnnH`, reset addr to `DUMP_START` → IDLE.
- Line format, 27 chars:
  - index 0–6: "Offset ".
  - index 7–14: addr nibbles [31:28] down to [3:0].
  - index 15–17: " : ".
  - index 18–25: data nibbles [31:28] down to [3:0].
  - index 26: 0x0A.
  - Nibble to ASCII: 0–9 → 0x30–0x39; a–f → 0x61–0x66 (lowercase).
- UART frame: start bit 0, data bits D0..D7, stop bit 1; each bit held exactly `BAUD_DIV` cycles. The baud counter restarts at every frame start.
- Address counter is 32 bits; the range never wraps, because `DUMP_END` > `DUMP_START` is required.
- `StartQnnnH` while busy (any state ≠ IDLE) is ignored; no queuing.
- Reset mid-operation aborts the dump:
  - next cycle `UartTxQnnnH`=1; the partial frame is truncated.
  - no `DoneQnnnH` pulse.
  - all outputs take their reset values.
- Memory data is read once per word; later memory changes do not affect a line already captured.

## Timing
- Start sampled at cycle T (in IDLE):
  - T+1: `MemRdEnQ100H`=1, `BusyQnnnH`=1.
  - T+2: data captured.
  - T+3: `UartTxQnnnH` falls (start bit of 'O').
- Back-to-back chars within a line: next start bit in the cycle right after the previous stop bit ends; no idle gap.
- Between lines: exactly 3 idle-high cycles (NEXT_WORD, RD_REQ, RD_CAP) between the '\n' stop bit end and the next 'O' start bit.
- Per line: 270×`BAUD_DIV` cycles of TX.
- Total duration, N = (`DUMP_END`−`DUMP_START`)/4:
  - `BusyQnnnH` high for N×(270×`BAUD_DIV`+3) cycles.
  - `DoneQnnnH` asserted 2 cycles after the last stop bit ends (NEXT_WORD, then DONE).
- Earliest restart: `StartQnnnH` is accepted in the cycle after `DoneQnnnH`.

## Test plan
- `BAUD_DIV`=4, range 0x400000–0x400004, mem=0xDEADBEEF, one start pulse:
  - UART monitor decodes exactly "Offset 00400000 : deadbeef\n".
  - First start bit at T+3.
  - `DoneQnnnH` at T+3+1080+2−1; one pulse.
- `BAUD_DIV`=4, 3 words [0x00000000, 0x12345678, 0xFFFFFFFF] at 0x400C00:
  - 3 lines, addresses 00400c00/00400c04/00400c08.
  - Exactly 3 idle cycles between lines.
  - `MemRdEnQ100H` pulses exactly 3 times.
- Bit timing, `BAUD_DIV`=7: every TX bit level holds exactly 7 cycles; stop bits = 1; LSB first ('O'=0x4F → 1,1,1,1,0,0,1,0).
- `StartQnnnH` held high for the full dump plus repeated pulses mid-line:
  - exactly one dump.
  - a new dump begins only when start is sampled in IDLE.
- `RstQnnnH` asserted during data bit 3 of char 10, line 2:
  - TX high next cycle.
  - `BusyQnnnH`=0.
  - no `DoneQnnnH`.
  - a subsequent start replays from `DUMP_START`.
- Memory changed after capture, during TX of the same line: transmitted data equals the value at capture.

Source files
------------

// File: rtl/lotr_uart_snapshot.sv
// lotr_uart_snapshot
//   Reads a word range of LOTR data memory through a synchronous read port and
//   prints every word on a UART TX line as "Offset XXXXXXXX : YYYYYYYY\n",
//   matching the simulation shared-memory log so silicon and sim dumps diff cleanly.
//
// Parameters
//   BAUD_DIV    clock cycles per UART bit (>= 2)
//   DUMP_START  first byte address dumped (word aligned)
//   DUMP_END    exclusive end byte address (word aligned, > DUMP_START)
//
// Ports
//   QClk            clock
//   RstQnnnH        synchronous active-high reset
//   StartQnnnH      start request, accepted only while idle
//   MemRdEnQ100H    read strobe to data memory
//   MemAdrsQ100H    byte address of the word read (zero when not reading)
//   MemRdDataQ101H  read data, valid the cycle after the strobe
//   UartTxQnnnH     serial out, 8N1, LSB first, idle high
//   BusyQnnnH       dump in progress
//   DoneQnnnH       one-cycle pulse after the final stop bit
module lotr_uart_snapshot #(
    parameter int          BAUD_DIV   = 434,
    parameter logic [31:0] DUMP_START = 32'h0040_0C00,
    parameter logic [31:0] DUMP_END   = 32'h0040_1000
) (
    input  logic        QClk,
    input  logic        RstQnnnH,
    input  logic        StartQnnnH,
    output logic        MemRdEnQ100H,
    output logic [31:0] MemAdrsQ100H,
    input  logic [31:0] MemRdDataQ101H,
    output logic        UartTxQnnnH,
    output logic        BusyQnnnH,
    output logic        DoneQnnnH
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD_REQ    = 3'd1;
    localparam logic [2:0] S_RD_CAP    = 3'd2;
    localparam logic [2:0] S_TX_CHAR   = 3'd3;
    localparam logic [2:0] S_NEXT_WORD = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    localparam int          BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [55:0] PREFIX    = "Offset ";
    localparam logic [4:0]  LAST_CHAR = 5'd26;
    localparam logic [3:0]  STOP_BIT  = 4'd9;

    logic [2:0]    state;
    logic [31:0]   addr;
    logic [31:0]   data_q;
    logic [4:0]    char_idx;
    logic [3:0]    bit_idx;   // 0 = start, 1..8 = D0..D7, 9 = stop
    logic [BW-1:0] baud_cnt;
    logic          tx_q;
    logic [7:0]    cur_char;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // Character of the current line selected by char_idx.
    always_comb begin
        int i;
        i        = int'(char_idx);
        cur_char = 8'h0A;
        if (char_idx < 5'd7)
            cur_char = PREFIX[8*(6-i) +: 8];
        else if (char_idx < 5'd15)
            cur_char = hex_ascii(addr[4*(14-i) +: 4]);
        else if (char_idx == 5'd16)
            cur_char = 8'h3A;
        else if (char_idx < 5'd18)
            cur_char = 8'h20;
        else if (char_idx < 5'd26)
            cur_char = hex_ascii(data_q[4*(25-i) +: 4]);
    end

    // TX is registered: each bit level is loaded on the cycle before it is
    // driven, so the line is glitch-free and a frame starts right after RD_CAP.
    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            state    <= S_IDLE;
            addr     <= DUMP_START;
            data_q   <= '0;
            char_idx <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (StartQnnnH)
                        state <= S_RD_REQ;
                end
                S_RD_REQ: begin
                    state <= S_RD_CAP;
                end
                S_RD_CAP: begin
                    data_q   <= MemRdDataQ101H;
                    char_idx <= '0;
                    bit_idx  <= '0;
                    baud_cnt <= '0;
                    tx_q     <= 1'b0;
                    state    <= S_TX_CHAR;
                end
                S_TX_CHAR: begin
                    if (baud_cnt != BAUD_LAST) begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end else begin
                        baud_cnt <= '0;
                        if (bit_idx == STOP_BIT) begin
                            bit_idx <= '0;
                            if (char_idx == LAST_CHAR) begin
                                tx_q  <= 1'b1;
                                state <= S_NEXT_WORD;
                            end else begin
                                char_idx <= char_idx + 1'b1;
                                tx_q     <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            // leaving bit b: next is data bit b, or stop after D7
                            tx_q    <= (bit_idx == 4'd8) ? 1'b1 : cur_char[bit_idx[2:0]];
                        end
                    end
                end
                S_NEXT_WORD: begin
                    if (addr + 32'd4 == DUMP_END) begin
                        state <= S_DONE;
                    end else begin
                        addr  <= addr + 32'd4;
                        state <= S_RD_REQ;
                    end
                end
                S_DONE: begin
                    addr  <= DUMP_START;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign MemRdEnQ100H = (state == S_RD_REQ);
    // Address bus is held at zero outside read strobes.
    assign MemAdrsQ100H = MemRdEnQ100H ? addr : '0;
    assign UartTxQnnnH  = tx_q;
    assign BusyQnnnH    = (state == S_RD_REQ) || (state == S_RD_CAP) ||
                          (state == S_TX_CHAR) || (state == S_NEXT_WORD);
    assign DoneQnnnH    = (state == S_DONE);

endmodule

// File: tb/tb_lotr_uart_snapshot.sv
module tb_lotr_uart_snapshot;

    localparam int          B  = 4;
    localparam logic [31:0] DS = 32'h0040_0C00;
    localparam logic [31:0] DE = 32'h0040_0C0C;
    localparam int          N  = (DE - DS) / 4;
    localparam int          P  = 270 * B + 3;   // cycles per line including overhead
    localparam int          D  = N * P + 1;     // start cycle to Done cycle

    logic        QClk;
    logic        RstQnnnH;
    logic        StartQnnnH;
    logic        MemRdEnQ100H;
    logic [31:0] MemAdrsQ100H;
    logic [31:0] MemRdDataQ101H;
    logic        UartTxQnnnH;
    logic        BusyQnnnH;
    logic        DoneQnnnH;

    lotr_uart_snapshot #(
        .BAUD_DIV   (B),
        .DUMP_START (DS),
        .DUMP_END   (DE)
    ) dut (
        .QClk           (QClk),
        .RstQnnnH       (RstQnnnH),
        .StartQnnnH     (StartQnnnH),
        .MemRdEnQ100H   (MemRdEnQ100H),
        .MemAdrsQ100H   (MemAdrsQ100H),
        .MemRdDataQ101H (MemRdDataQ101H),
        .UartTxQnnnH    (UartTxQnnnH),
        .BusyQnnnH      (BusyQnnnH),
        .DoneQnnnH      (DoneQnnnH)
    );

    initial QClk = 1'b0;
    always #5 QClk = ~QClk;

    longint cyc = 0;
    always @(posedge QClk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard queues filled by the stimulus, drained by the monitors.
    typedef struct {
        logic [7:0] ch;
        int         gap;   // -1: first char of a dump, check absolute start cycle
        longint     t0;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    longint      done_q[$];
    logic [31:0] mem[N];

    // Memory model: one-cycle read latency, garbage when not reading.
    logic        rd_seen;
    logic [31:0] rd_word;
    always @(negedge QClk) begin
        rd_seen = 1'b0;
        if (MemRdEnQ100H && !RstQnnnH) begin
            chk("rd_expected", addr_q.size() > 0, 1);
            if (addr_q.size() > 0) chk("rd_addr", MemAdrsQ100H, addr_q.pop_front());
            rd_seen = 1'b1;
            if (MemAdrsQ100H >= DS && MemAdrsQ100H < DE && MemAdrsQ100H[1:0] == 2'b00)
                rd_word = mem[(MemAdrsQ100H - DS) >> 2];
            else
                rd_word = $urandom;
        end
    end
    always @(posedge QClk) MemRdDataQ101H <= rd_seen ? rd_word : $urandom;

    // UART / Done monitor, sampling on the falling edge.
    bit         in_frame  = 0;
    bit         have_last = 0;
    bit         cur_valid = 0;
    bit         hold_err  = 0;
    longint     fs, last_stop;
    int         p, bitn, ph;
    logic       lvl, stop_lvl;
    logic [7:0] rx_byte;
    exp_t       cur;

    always @(negedge QClk) begin
        if (RstQnnnH) begin
            in_frame  = 0;
            have_last = 0;
        end else begin
            if (DoneQnnnH) begin
                chk("done_expected", done_q.size() > 0, 1);
                if (done_q.size() > 0) chk("done_cycle", cyc, done_q.pop_front());
            end
            if (!in_frame && !UartTxQnnnH) begin
                in_frame = 1;
                fs       = cyc;
                hold_err = 0;
                chk("frame_expected", exp_q.size() > 0, 1);
                cur_valid = (exp_q.size() > 0);
                if (cur_valid) begin
                    cur = exp_q.pop_front();
                    if (cur.gap < 0)
                        chk("first_start_cycle", fs, cur.t0);
                    else if (have_last)
                        chk("idle_gap", fs - last_stop - 1, cur.gap);
                end
            end
            if (in_frame) begin
                p    = int'(cyc - fs);
                bitn = p / B;
                ph   = p % B;
                if (ph == 0) begin
                    lvl = UartTxQnnnH;
                    if (bitn >= 1 && bitn <= 8) rx_byte[bitn-1] = UartTxQnnnH;
                    if (bitn == 9) stop_lvl = UartTxQnnnH;
                end else if (UartTxQnnnH !== lvl) begin
                    hold_err = 1;
                end
                if (p == 10 * B - 1) begin
                    chk("bit_hold", hold_err, 0);
                    chk("stop_bit", stop_lvl, 1);
                    if (cur_valid) chk("char", rx_byte, cur.ch);
                    in_frame  = 0;
                    have_last = 1;
                    last_stop = cyc;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge QClk);
        #1;
    endtask

    // One dump. hold: start held high until Done; pulses: random start pulses
    // while busy; mutate: rewrite each word after it has been captured;
    // abort_line >= 0: reset during data bit 3 of char 10 of that line.
    task automatic run_dump(input bit hold, input bit pulses, input bit mutate,
                            input int abort_line);
        longint T;
        string  s;
        exp_t   e;
        int     kr;
        @(posedge QClk);
        #1;
        T = cyc;
        for (int w = 0; w < N; w++) begin
            s = $sformatf("Offset %08h : %08h\n", DS + 32'(4 * w), mem[w]);
            for (int i = 0; i < 27; i++) begin
                e.ch  = s[i];
                e.gap = (i > 0) ? 0 : ((w == 0) ? -1 : 3);
                e.t0  = T + 3;
                exp_q.push_back(e);
            end
            addr_q.push_back(DS + 32'(4 * w));
        end
        if (abort_line < 0) done_q.push_back(T + D);
        StartQnnnH = 1'b1;
        kr = 3 + abort_line * P + 100 * B + 4 * B + 1;
        for (int k = 1; k <= D; k++) begin
            @(posedge QClk);
            #1;
            if (hold)
                StartQnnnH = (k < D);
            else if (pulses)
                StartQnnnH = (k < D - 1) && ($urandom_range(0, 7) == 0);
            else
                StartQnnnH = 1'b0;
            if (k == 1) begin
                chk("busy_t1", BusyQnnnH, 1);
                chk("rden_t1", MemRdEnQ100H, 1);
                chk("adrs_t1", MemAdrsQ100H, DS);
            end
            if (mutate)
                for (int w = 0; w < N; w++)
                    if (k == 2 + w * P + 50) mem[w] = $urandom;
            if (abort_line >= 0 && k == kr) RstQnnnH = 1'b1;
            if (abort_line >= 0 && k == kr + 1) begin
                RstQnnnH   = 1'b0;
                StartQnnnH = 1'b0;
                chk("abort_tx", UartTxQnnnH, 1);
                chk("abort_busy", BusyQnnnH, 0);
                chk("abort_done", DoneQnnnH, 0);
                chk("abort_rden", MemRdEnQ100H, 0);
                exp_q.delete();
                addr_q.delete();
                break;
            end
            if (abort_line < 0 && k == D - 1) chk("busy_before_done", BusyQnnnH, 1);
            if (abort_line < 0 && k == D) begin
                chk("busy_at_done", BusyQnnnH, 0);
                chk("done_at_end", DoneQnnnH, 1);
                chk("chars_left", exp_q.size(), 0);
                chk("reads_left", addr_q.size(), 0);
            end
        end
    endtask

    initial begin
        RstQnnnH   = 1'b1;
        StartQnnnH = 1'b0;
        for (int w = 0; w < N; w++) mem[w] = '0;
        idle(3);
        chk("rst_tx", UartTxQnnnH, 1);
        chk("rst_rden", MemRdEnQ100H, 0);
        chk("rst_adrs", MemAdrsQ100H, 0);
        chk("rst_busy", BusyQnnnH, 0);
        chk("rst_done", DoneQnnnH, 0);
        RstQnnnH = 1'b0;
        idle(5);

        mem[0] = 32'h0000_0000;
        mem[1] = 32'h1234_5678;
        mem[2] = 32'hFFFF_FFFF;
        run_dump(0, 0, 0, -1);
        idle(10);

        for (int w = 0; w < N; w++) mem[w] = $urandom;
        run_dump(1, 0, 1, -1);
        run_dump(0, 1, 1, -1);   // earliest restart, cycle after Done
        idle(5);

        for (int w = 0; w < N; w++) mem[w] = $urandom;
        run_dump(0, 0, 0, 1);
        idle(2500);
        run_dump(0, 0, 0, -1);

        idle(20);
        chk("final_chars_left", exp_q.size(), 0);
        chk("final_reads_left", addr_q.size(), 0);
        chk("final_done_left", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
